muldiv: RTL and testbench

Iterative multiply/divide unit owning the HI and LO registers of the integer pipeline. It sits directly downstream of the register file: it consumes the two register read operands (Rs, Rt) at issue and runs MULT/MULTU/DIV/DIVU over multiple cycles. It also executes MTHI/MTLO, and presents HI/LO for MFHI/MFLO. The pipeline stalls any HI/LO consumer or new mul/div issue while Busy is high.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_signfix.sv | 25 ++
 rtl/muldiv.sv | 140 ++++++++++++++
 tb/tb_muldiv.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

    localparam int ITERATIONS = 32;

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling: operand magnitudes on the way in,
// product negation and quotient/remainder sign correction on the way out.
module muldiv_signfix (
    input  logic        signedOp,
    input  logic [31:0] rsIn,
    input  logic [31:0] rtIn,
    output logic [31:0] rsAbs,
    output logic [31:0] rtAbs,
    input  logic [63:0] result,
    input  logic        resultNeg,
    input  logic        remainderNeg,
    output logic [63:0] productFixed,
    output logic [31:0] quotientFixed,
    output logic [31:0] remainderFixed
);

    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    assign rsAbs = (signedOp && rsIn[31]) ? -rsIn : rsIn;
    assign rtAbs = (signedOp && rtIn[31]) ? -rtIn : rtIn;

    assign productFixed   = resultNeg    ? -result        : result;
    assign quotientFixed  = resultNeg    ? -result[31:0]  : result[31:0];
    assign remainderFixed = remainderNeg ? -result[63:32] : result[63:32];

endmodule

// File: rtl/muldiv.sv
// Iterative 32-bit multiply/divide unit owning HI/LO (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Define MULDIV_FAST_MUL_EN to compute multiplies in a single cycle instead of 32 iterations.
module muldiv
    import muldiv_pkg::*;
(
    input  logic        Clock,
    input  logic        nReset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    input  logic        HiWrite,
    input  logic        LoWrite,
    output logic        Busy,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    state_t      state;
    op_t         opReg;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [63:0] acc;
    logic [5:0]  counter;
    logic        resultNeg;
    logic        remainderNeg;
    logic        divZero;

    logic        signedOp;
    logic        isDivide;
    logic        startDivZero;
    logic [31:0] rsAbs;
    logic [31:0] rtAbs;
    logic [63:0] productFixed;
    logic [31:0] quotientFixed;
    logic [31:0] remainderFixed;
    logic [32:0] mulSum;
    logic [32:0] divShift;
    logic [32:0] divDiff;

    assign signedOp     = (op_t'(Op) == MULT) || (op_t'(Op) == DIV);
    assign isDivide     = (opReg == DIV) || (opReg == DIVU);
    assign startDivZero = Op[1] && (RtData == 32'd0);

    muldiv_signfix signfix (
        .signedOp      (signedOp),
        .rsIn          (RsData),
        .rtIn          (RtData),
        .rsAbs         (rsAbs),
        .rtAbs         (rtAbs),
        .result        (acc),
        .resultNeg     (resultNeg),
        .remainderNeg  (remainderNeg),
        .productFixed  (productFixed),
        .quotientFixed (quotientFixed),
        .remainderFixed(remainderFixed)
    );

    // acc is {high, low}: multiply shifts the product in from the top, divide
    // holds {remainder, quotient} while the dividend bits shift out of opA.
    always_comb begin
        mulSum   = {1'b0, acc[63:32]} + (opB[0] ? {1'b0, opA} : 33'd0);
        divShift = {acc[63:32], opA[31]};
        divDiff  = divShift - {1'b0, opB};
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state        <= IDLE;
            opReg        <= MULT;
            opA          <= '0;
            opB          <= '0;
            acc          <= '0;
            counter      <= '0;
            resultNeg    <= 1'b0;
            remainderNeg <= 1'b0;
            divZero      <= 1'b0;
            Busy         <= 1'b0;
            Hi           <= '0;
            Lo           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        opReg        <= op_t'(Op);
                        opA          <= startDivZero ? RsData : rsAbs;
                        opB          <= rtAbs;
                        acc          <= '0;
                        counter      <= '0;
                        resultNeg    <= signedOp && (RsData[31] ^ RtData[31]);
                        remainderNeg <= signedOp && RsData[31];
                        divZero      <= startDivZero;
                        Busy         <= 1'b1;
                        if (startDivZero) begin
                            state <= FIX;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!Op[1]) begin
                            acc   <= {32'd0, rsAbs} * {32'd0, rtAbs};
                            state <= FIX;
`endif
                        end else begin
                            state <= CALC;
                        end
                    end else begin
                        if (HiWrite) Hi <= RsData;
                        if (LoWrite) Lo <= RsData;
                    end
                end
                CALC: begin
                    counter <= counter + 6'd1;
                    if (isDivide) begin
                        acc <= {(divDiff[32] ? divShift[31:0] : divDiff[31:0]),
                                acc[30:0], ~divDiff[32]};
                        opA <= {opA[30:0], 1'b0};
                    end else begin
                        acc <= {mulSum, acc[31:1]};
                        opB <= {1'b0, opB[31:1]};
                    end
                    if (counter == 6'(ITERATIONS - 1)) state <= FIX;
                end
                FIX: begin
                    if (divZero) begin
                        Hi <= opA;
                        Lo <= 32'hFFFF_FFFF;
                    end else if (isDivide) begin
                        Hi <= remainderFixed;
                        Lo <= quotientFixed;
                    end else begin
                        Hi <= productFixed[63:32];
                        Lo <= productFixed[31:0];
                    end
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: a scoreboard of expected {Hi, Lo, busy cycles}
// pushed at issue and popped when Busy falls.
module tb_muldiv;
    import muldiv_pkg::*;

    logic        Clock = 1'b0;
    logic        nReset = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] RsData = '0;
    logic [31:0] RtData = '0;
    logic        HiWrite = 1'b0;
    logic        LoWrite = 1'b0;
    logic        Busy;
    logic [31:0] Hi;
    logic [31:0] Lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        expQ[$];
    int          testsRun = 0;
    int          testsFailed = 0;
    logic [31:0] modelHi = '0;
    logic [31:0] modelLo = '0;
    logic        holdBad = 1'b0;

    always #5 Clock = ~Clock;

    muldiv dut (
        .Clock  (Clock),
        .nReset (nReset),
        .Start  (Start),
        .Op     (Op),
        .RsData (RsData),
        .RtData (RtData),
        .HiWrite(HiWrite),
        .LoWrite(LoWrite),
        .Busy   (Busy),
        .Hi     (Hi),
        .Lo     (Lo)
    );

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        sa = op[0] ? longint'({32'd0, a}) : longint'($signed(a));
        sb = op[0] ? longint'({32'd0, b}) : longint'($signed(b));
        if (op[1] && b == 32'd0) begin
            e.hi = a;
            e.lo = 32'hFFFF_FFFF;
            e.cycles = 1;
        end else if (!op[1]) begin
            if (op[0]) p = {32'd0, a} * {32'd0, b};
            else       p = 64'(sa * sb);
            e.hi = p[63:32];
            e.lo = p[31:0];
`ifdef MULDIV_FAST_MUL_EN
            e.cycles = 1;
`else
            e.cycles = 33;
`endif
        end else begin
            q = sa / sb;
            r = sa % sb;
            e.hi = r[31:0];
            e.lo = q[31:0];
            e.cycles = 33;
        end
        return e;
    endfunction

    task automatic issueOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic hw, input logic lw, input logic track);
        @(negedge Clock);
        Op = op;
        RsData = a;
        RtData = b;
        HiWrite = hw;
        LoWrite = lw;
        Start = 1'b1;
        if (track) expQ.push_back(model(op, a, b));
        holdBad = 1'b0;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        HiWrite = 1'b0;
        LoWrite = 1'b0;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        while (Busy === 1'b1 && cycles < 200) begin
            if (Hi !== modelHi || Lo !== modelLo) holdBad = 1'b1;
            @(posedge Clock);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        #1;
        testsRun++;
        if (Busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy got %b want 0", Busy); end
        testsRun++;
        if (Hi !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_hi got %h want 0", Hi); end
        testsRun++;
        if (Lo !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_lo got %h want 0", Lo); end
        @(negedge Clock);
        nReset = 1'b1;
    endtask

    task automatic test_arith(input string tag, input logic [1:0] ops[], input logic [31:0] as[],
                              input logic [31:0] bs[]);
        exp_t e;
        int   cyc;
        for (int i = 0; i < ops.size(); i++) begin
            issueOp(ops[i], as[i], bs[i], 1'b0, 1'b0, 1'b1);
            waitDone(cyc);
            e = expQ.pop_front();
            testsRun++;
            if (cyc !== e.cycles) begin testsFailed++; $display("[TB] FAIL %s[%0d]_busy_cycles got %0d want %0d", tag, i, cyc, e.cycles); end
            testsRun++;
            if (Hi !== e.hi) begin testsFailed++; $display("[TB] FAIL %s[%0d]_hi got %h want %h", tag, i, Hi, e.hi); end
            testsRun++;
            if (Lo !== e.lo) begin testsFailed++; $display("[TB] FAIL %s[%0d]_lo got %h want %h", tag, i, Lo, e.lo); end
            testsRun++;
            if (holdBad !== 1'b0) begin testsFailed++; $display("[TB] FAIL %s[%0d]_hold got %b want 0", tag, i, holdBad); end
            modelHi = e.hi;
            modelLo = e.lo;
        end
    endtask

    task automatic test_multiply();
        logic [1:0]  ops[];
        logic [31:0] as[];
        logic [31:0] bs[];
        ops = '{MULT, MULTU, MULT, MULT, MULTU};
        as  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h8000_0000, 32'd7, 32'd6};
        bs  = '{32'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF9, 32'd7};
        test_arith("mul", ops, as, bs);
    endtask

    task automatic test_divide();
        logic [1:0]  ops[];
        logic [31:0] as[];
        logic [31:0] bs[];
        ops = '{DIV, DIVU, DIV, DIV, DIVU, DIVU, DIV};
        as  = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd7, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFF0};
        bs  = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd0, 32'd0};
        test_arith("div", ops, as, bs);
    endtask

    task automatic test_move();
        exp_t e;
        int   cyc;
        @(negedge Clock);
        RsData = 32'hCAFE_0001;
        HiWrite = 1'b1;
        LoWrite = 1'b1;
        @(posedge Clock);
        #1;
        HiWrite = 1'b0;
        LoWrite = 1'b0;
        testsRun++;
        if (Hi !== 32'hCAFE_0001) begin testsFailed++; $display("[TB] FAIL mtboth_hi got %h want cafe0001", Hi); end
        testsRun++;
        if (Lo !== 32'hCAFE_0001) begin testsFailed++; $display("[TB] FAIL mtboth_lo got %h want cafe0001", Lo); end
        testsRun++;
        if (Busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL mtboth_busy got %b want 0", Busy); end
        modelHi = 32'hCAFE_0001;
        modelLo = 32'hCAFE_0001;
        // Start with both writes asserted: the op result must win
        issueOp(MULTU, 32'd2, 32'd3, 1'b1, 1'b1, 1'b1);
        waitDone(cyc);
        e = expQ.pop_front();
        testsRun++;
        if (Hi !== e.hi) begin testsFailed++; $display("[TB] FAIL start_wins_hi got %h want %h", Hi, e.hi); end
        testsRun++;
        if (Lo !== e.lo) begin testsFailed++; $display("[TB] FAIL start_wins_lo got %h want %h", Lo, e.lo); end
        modelHi = e.hi;
        modelLo = e.lo;
    endtask

    task automatic test_start_while_busy();
        exp_t e;
        int   cyc;
        @(negedge Clock);
        RsData = 32'h1234_5678;
        HiWrite = 1'b1;
        @(posedge Clock);
        #1;
        HiWrite = 1'b0;
        testsRun++;
        if (Hi !== 32'h1234_5678) begin testsFailed++; $display("[TB] FAIL mthi_hi got %h want 12345678", Hi); end
        testsRun++;
        if (Lo !== modelLo) begin testsFailed++; $display("[TB] FAIL mthi_lo got %h want %h", Lo, modelLo); end
        modelHi = 32'h1234_5678;
        issueOp(DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 1'b1);
        repeat (5) @(posedge Clock);
        @(negedge Clock);
        Op = MULTU;
        RsData = 32'd3;
        RtData = 32'd3;
        Start = 1'b1;
        HiWrite = 1'b1;
        LoWrite = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        HiWrite = 1'b0;
        LoWrite = 1'b0;
        waitDone(cyc);
        e = expQ.pop_front();
        testsRun++;
        if (cyc !== 27) begin testsFailed++; $display("[TB] FAIL busy_ignore_cycles got %0d want 27", cyc); end
        testsRun++;
        if (Hi !== e.hi || Lo !== e.lo) begin testsFailed++; $display("[TB] FAIL busy_ignore_result got %h_%h want %h_%h", Hi, Lo, e.hi, e.lo); end
        testsRun++;
        if (holdBad !== 1'b0) begin testsFailed++; $display("[TB] FAIL busy_ignore_hold got %b want 0", holdBad); end
        modelHi = e.hi;
        modelLo = e.lo;
        @(posedge Clock);
        #1;
        testsRun++;
        if (Busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL busy_no_queue got %b want 0", Busy); end
    endtask

    task automatic test_reset_midop();
        exp_t e;
        int   cyc;
        issueOp(DIV, 32'hFFFF_FF00, 32'd3, 1'b0, 1'b0, 1'b0);
        repeat (9) @(posedge Clock);
        @(negedge Clock);
        nReset = 1'b0;
        #1;
        testsRun++;
        if (Busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_busy got %b want 0", Busy); end
        testsRun++;
        if (Hi !== 32'd0 || Lo !== 32'd0) begin testsFailed++; $display("[TB] FAIL midreset_hilo got %h_%h want 0_0", Hi, Lo); end
        modelHi = '0;
        modelLo = '0;
        @(negedge Clock);
        nReset = 1'b1;
        issueOp(MULTU, 32'd6, 32'd7, 1'b0, 1'b0, 1'b1);
        waitDone(cyc);
        e = expQ.pop_front();
        testsRun++;
        if (Lo !== 32'd42 || Lo !== e.lo) begin testsFailed++; $display("[TB] FAIL after_reset_lo got %h want 2a", Lo); end
        testsRun++;
        if (Hi !== 32'd0 || Hi !== e.hi) begin testsFailed++; $display("[TB] FAIL after_reset_hi got %h want 0", Hi); end
        modelHi = e.hi;
        modelLo = e.lo;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops[];
        logic [31:0] as[];
        logic [31:0] bs[];
        ops = '{MULTU, DIV, MULT, DIVU};
        as  = '{32'd10, 32'hFFFF_FF9C, 32'h7FFF_FFFF, 32'hDEAD_BEEF};
        bs  = '{32'd20, 32'd7, 32'h7FFF_FFFF, 32'h0001_0000};
        test_arith("b2b", ops, as, bs);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_move();
        test_start_while_busy();
        test_reset_midop();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
